// File: rtl/store_narrow_unit.sv
// ============================================================================
// Module      : store_narrow_unit
// Description : Narrows store data to byte/half/word, steers it onto memory
//               byte lanes and buffers it in a DEPTH-entry FIFO.
//               Optional macro STORE_MISALIGN_TRAP_EN adds a misalignment trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_narrow_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
`ifdef STORE_MISALIGN_TRAP_EN
  output logic        misalign_err,
  output logic [31:0] err_addr,
`endif
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [29:0]     r_addr_q [DEPTH];
  logic [31:0]     r_data_q [DEPTH];
  logic [3:0]      r_be_q   [DEPTH];

  logic [31:0]     w_wdata;
  logic [3:0]      w_be;
  logic            w_size_ok;
  logic            w_misalign;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count_nxt;

  // Lane steering; size 11 is consumed by the handshake but never enqueued.
  always_comb begin
    w_wdata   = req_data;
    w_be      = 4'b1111;
    w_size_ok = 1'b1;
    case (req_size)
      2'b00: begin
        w_wdata = {4{req_data[7:0]}};
        w_be    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{req_data[15:0]}};
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        w_wdata = req_data;
        w_be    = 4'b1111;
      end
      default: w_size_ok = 1'b0;
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign req_ready = (r_state != S_FULL);
  assign mem_valid = (r_state != S_EMPTY);
  assign busy      = mem_valid;
  assign w_accept  = req_valid & req_ready;
  assign w_push    = w_accept & w_size_ok & ~w_misalign;
  assign w_pop     = mem_valid & mem_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_EMPTY;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case (r_state)
        S_EMPTY:   if (w_push) r_state <= (w_count_nxt == CW'(DEPTH)) ? S_FULL : S_PARTIAL;
        S_PARTIAL: begin
          if (w_count_nxt == CW'(DEPTH))  r_state <= S_FULL;
          else if (w_count_nxt == '0)     r_state <= S_EMPTY;
        end
        S_FULL:    if (w_pop) r_state <= (w_count_nxt == '0) ? S_EMPTY : S_PARTIAL;
        default:   r_state <= S_EMPTY;
      endcase
    end
  end

  // Payload storage needs no reset: it is only visible while an entry is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_q[r_wr_ptr] <= req_addr[31:2];
      r_data_q[r_wr_ptr] <= w_wdata;
      r_be_q[r_wr_ptr]   <= w_be;
    end
  end

  assign mem_addr  = mem_valid ? {r_addr_q[r_rd_ptr], 2'b00} : 32'd0;
  assign mem_wdata = mem_valid ? r_data_q[r_rd_ptr] : 32'd0;
  assign mem_be    = mem_valid ? r_be_q[r_rd_ptr] : 4'd0;

`ifdef STORE_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
      err_addr     <= 32'd0;
    end else begin
      misalign_err <= w_accept & w_misalign;
      if (w_accept & w_misalign) err_addr <= req_addr;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_narrow_unit.sv
// ============================================================================
// Module      : tb_store_narrow_unit
// Description : Directed self-checking bench for store_narrow_unit (DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;
`ifdef STORE_MISALIGN_TRAP_EN
  logic        misalign_err;
  logic [31:0] err_addr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_narrow_unit #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_size    (req_size),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
`ifdef STORE_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
    .err_addr    (err_addr),
`endif
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
  endtask

  task automatic check_mem(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    check({tag, "_valid"}, {31'd0, mem_valid}, 32'd1);
    check({tag, "_addr"},  mem_addr,  a);
    check({tag, "_wdata"}, mem_wdata, d);
    check({tag, "_be"},    {28'd0, mem_be}, {28'd0, be});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, mem_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_be"},    {28'd0, mem_be},    32'd0);
    check({tag, "_wdata"}, mem_wdata,          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    #1;
    step();
    step();
    check_idle("reset");
    check("reset_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    step();

    // Byte store into lane 3
    drive(1'b1, 32'h103, 32'hAABBCCDD, 2'b00);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check_mem("byte", 32'h100, 32'hDDDDDDDD, 4'b1000);
    mem_ready = 1'b1;
    step();
    check_idle("byte_pop");

    // Half store into upper lanes
    mem_ready = 1'b0;
    drive(1'b1, 32'h22, 32'h1234BEEF, 2'b01);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check_mem("half", 32'h20, 32'hBEEFBEEF, 4'b1100);
    mem_ready = 1'b1;
    step();

    // Byte into lane 1, half into lower lanes
    mem_ready = 1'b0;
    drive(1'b1, 32'h201, 32'h000000A5, 2'b00);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check_mem("byte1", 32'h200, 32'hA5A5A5A5, 4'b0010);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    drive(1'b1, 32'h300, 32'hFFFF5A3C, 2'b01);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check_mem("half0", 32'h300, 32'h5A3C5A3C, 4'b0011);
    mem_ready = 1'b1;
    step();

    // Fill with memory stalled, then drain in order
    mem_ready = 1'b0;
    drive(1'b1, 32'h10, 32'h00000011, 2'b00);
    step();
    drive(1'b1, 32'h24, 32'hCAFEF00D, 2'b10);
    step();
    check("full_ready", {31'd0, req_ready}, 32'd0);
    check_mem("full_head", 32'h10, 32'h11111111, 4'b0001);
    drive(1'b1, 32'h88, 32'h99999999, 2'b10);
    step();
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check_mem("stall_hold", 32'h10, 32'h11111111, 4'b0001);
    mem_ready = 1'b1;
    step();
    check_mem("drain2", 32'h24, 32'hCAFEF00D, 4'b1111);
    check("drain_ready", {31'd0, req_ready}, 32'd1);
    step();
    check("drain_busy", {31'd0, busy}, 32'd0);

    // Simultaneous push and pop at count 1
    mem_ready = 1'b0;
    drive(1'b1, 32'h50, 32'h01020304, 2'b10);
    step();
    drive(1'b1, 32'h62, 32'h0000ABCD, 2'b01);
    mem_ready = 1'b1;
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    mem_ready = 1'b0;
    check_mem("pp_next", 32'h60, 32'hABCDABCD, 4'b1100);
    check("pp_ready", {31'd0, req_ready}, 32'd1);
    mem_ready = 1'b1;
    step();
    check("pp_busy", {31'd0, busy}, 32'd0);

    // Reserved size is consumed but never written
    drive(1'b1, 32'h70, 32'h77777777, 2'b11);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check_idle("rsvd");

    // Reset with two entries pending
    mem_ready = 1'b0;
    drive(1'b1, 32'h80, 32'h11, 2'b00);
    step();
    drive(1'b1, 32'h84, 32'h22, 2'b00);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    rst_n = 1'b0;
    step();
    check_idle("rst_mid");
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step();
    step();
    check("rst_after", {31'd0, mem_valid}, 32'd0);

    // Misaligned word
    mem_ready = 1'b0;
    drive(1'b1, 32'h41, 32'h12345678, 2'b10);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
`ifdef STORE_MISALIGN_TRAP_EN
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_eaddr", err_addr, 32'h41);
    check("mis_valid", {31'd0, mem_valid}, 32'd0);
    step();
    check("mis_pulse", {31'd0, misalign_err}, 32'd0);
    check("mis_hold", err_addr, 32'h41);
    check("mis_valid2", {31'd0, mem_valid}, 32'd0);
`else
    check_mem("mis_word", 32'h40, 32'h12345678, 4'b1111);
    mem_ready = 1'b1;
    step();
    check("mis_busy", {31'd0, busy}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
